// File: rtl/pacman_direction_controller_pkg.sv
// Shared direction encoding for the Pac-Man controller and the sprite position updater.
package pacman_direction_controller_pkg;

  typedef logic [3:0] dir_t;

  localparam dir_t DirNone  = 4'b0000;
  localparam dir_t DirRight = 4'b0001;
  localparam dir_t DirUp    = 4'b0010;
  localparam dir_t DirDown  = 4'b0100;
  localparam dir_t DirLeft  = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StMoving,
    StStalled
  } state_e;

  function automatic dir_t reverse_dir(dir_t d);
    dir_t r;
    case (d)
      DirRight: r = DirLeft;
      DirLeft:  r = DirRight;
      DirUp:    r = DirDown;
      DirDown:  r = DirUp;
      default:  r = DirNone;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pacman_direction_controller_if.sv
// Button, legal-move and direction-pulse signals between the board/updater side and the
// direction controller.
interface pacman_direction_controller_if;

  logic                                 enable;
  logic                                 btn_up;
  logic                                 btn_down;
  logic                                 btn_left;
  logic                                 btn_right;
  pacman_direction_controller_pkg::dir_t valid_moves;
  pacman_direction_controller_pkg::dir_t move_direction;
  pacman_direction_controller_pkg::dir_t heading;
  logic                                 stalled;

  modport master (
    output enable, btn_up, btn_down, btn_left, btn_right, valid_moves,
    input  move_direction, heading, stalled
  );

  modport slave (
    input  enable, btn_up, btn_down, btn_left, btn_right, valid_moves,
    output move_direction, heading, stalled
  );

endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability counter for one raw button; emits a one-cycle press
// pulse registered together with the debounced level's rising edge.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter tracks how long the synchronised input has disagreed with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/pacman_direction_controller.sv
// Turns debounced button presses into paced one-hot move pulses for the Pac-Man sprite,
// holding one queued turn and retrying the current heading against the legal-move mask.
module pacman_direction_controller
  import pacman_direction_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned STEP_PERIOD     = 5_000_000
) (
  input logic                          clk,
  input logic                          rst,
  pacman_direction_controller_if.slave bus
);

  localparam int unsigned StepW = $clog2(STEP_PERIOD);
  localparam logic [StepW-1:0] StepMax = StepW'(STEP_PERIOD - 1);

  logic [3:0] btn_raw;
  dir_t       press;  // bit positions follow the direction encoding
  dir_t       press_dir;

  assign btn_raw = {bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_right};

  for (genvar i = 0; i < 4; i++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .press(press[i])
    );
  end

  always_comb begin
    press_dir = DirNone;
    if ((press & DirUp) != DirNone)         press_dir = DirUp;
    else if ((press & DirDown) != DirNone)  press_dir = DirDown;
    else if ((press & DirLeft) != DirNone)  press_dir = DirLeft;
    else if ((press & DirRight) != DirNone) press_dir = DirRight;
  end

  logic [StepW-1:0] step_cnt_q, step_cnt_d;
  logic             step;

  assign step = bus.enable && (step_cnt_q == StepMax);

  always_comb begin
    step_cnt_d = '0;
    if (bus.enable && !step) step_cnt_d = step_cnt_q + 1'b1;
  end

  state_e state_q, state_d;
  dir_t   queued_q, queued_d;
  dir_t   heading_q, heading_d;
  dir_t   move_q, move_d;

  always_comb begin
    state_d   = state_q;
    queued_d  = queued_q;
    heading_d = heading_q;
    move_d    = DirNone;
    if (step) begin
      if (queued_q != DirNone && (bus.valid_moves & queued_q) != DirNone) begin
        move_d    = queued_q;
        heading_d = queued_q;
        queued_d  = DirNone;
        state_d   = StMoving;
      end else if (heading_q != DirNone && (bus.valid_moves & heading_q) != DirNone) begin
        move_d  = heading_q;
        state_d = StMoving;
      end else if (state_q != StIdle) begin
        state_d = StStalled;
      end
    end
    // A press landing on a step overrides the consume-clear above.
    if (press_dir != DirNone) queued_d = press_dir;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q <= '0;
      state_q    <= StIdle;
      queued_q   <= DirNone;
      heading_q  <= DirNone;
      move_q     <= DirNone;
    end else begin
      step_cnt_q <= step_cnt_d;
      state_q    <= state_d;
      queued_q   <= queued_d;
      heading_q  <= heading_d;
      move_q     <= move_d;
    end
  end

  assign bus.move_direction = move_q;
  assign bus.heading        = heading_q;
  assign bus.stalled        = (state_q == StStalled);

endmodule

// File: doc/pacman_direction_controller.md
# pacman_direction_controller

Converts the four raw player push-buttons into the one-cycle `move_direction` pulse consumed by the sprite position updater. It synchronises and debounces the buttons, and buffers the most recent press as a queued turn. A step timer paces the moves, and a one-hot direction is emitted once per step, chosen against the current `valid_moves` mask. It sits between the board button pins and the Pac-Man instance of the position updater, which it drives with `which_sprite` = 0.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a button level change; must be ≥ 1.
- `STEP_PERIOD`, default 5_000_000: clock cycles between move steps; must be ≥ 4.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `enable`, input, 1: game running; gates the step timer.
- `btn_up` / `btn_down` / `btn_left` / `btn_right`, input, 1 each: raw asynchronous buttons, active-high.
- `valid_moves`, input, 4: legal-move mask for the current Pac-Man position, one-hot directions OR-ed together.
- `move_direction`, output, 4: one-hot direction pulse, 0000 when no move is issued.
- `heading`, output, 4: current travel direction, used for sprite orientation; 0000 when idle.
- `stalled`, output, 1: high while the controller is in the STALLED state.

## Operation
- Direction encoding: RIGHT = 0001, UP = 0010, DOWN = 0100, LEFT = 1000.
- Button path:
  - Each button passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level changes only after the synchronised input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - A 0→1 edge of a debounced level is a press.
- Queue:
  - A single 4-bit `queued` register holds the latest press.
  - Simultaneous presses resolve by priority UP > DOWN > LEFT > RIGHT.
  - A newer press overwrites an older queued value.
  - `queued` is cleared only when it is consumed.
- Step timer:
  - Counts 0..`STEP_PERIOD`-1 while `enable` is high, wrapping to 0.
  - While `enable` is low the counter is held at 0, no steps occur, and presses are still queued.
- Step decision, made when the counter equals `STEP_PERIOD`-1:
  - If `queued` ≠ 0 and (`valid_moves` & `queued`) ≠ 0: emit `queued`, set `heading` ← `queued`, clear `queued`.
  - Else if `heading` ≠ 0 and (`valid_moves` & `heading`) ≠ 0: emit `heading`.
  - Otherwise emit nothing and go to STALLED.
- State machine:
  - IDLE (`heading` = 0) → MOVING on the first emitted move.
  - MOVING → STALLED when a step finds both the queued direction and `heading` blocked.
  - STALLED → MOVING when a step emits any move. A queued direction, or a retried `heading` that has become legal, both count.
  - `heading` is retained in STALLED.
- Reversal of direction needs no special case; it is an ordinary queued turn.

## Timing
- Reset values: `move_direction` = 0000, `heading` = 0000, `stalled` = 0, `queued` = 0, step counter = 0, debounced levels = 0, synchronisers = 0. The state is IDLE.
- Press latency: a press is visible in `queued` 2 (synchroniser) + `DEBOUNCE_CYCLES` + 1 cycles after the raw input first rises and stays stable.
- Step pulse timing: if the counter equals `STEP_PERIOD`-1 in cycle N, `move_direction` is non-zero only in cycle N+1, for exactly one cycle. `heading` and `stalled` update in that same cycle N+1.
- First step after `enable` rises: the pulse occurs `STEP_PERIOD` cycles after the first cycle in which `enable` is sampled high.
- `valid_moves` lag: `valid_moves` is sampled in cycle N. The updater's new position and the registered valid-move mask settle within 3 cycles of the pulse. `STEP_PERIOD` ≥ 4 therefore guarantees a fresh mask at the next step.
- Press and step in the same cycle: the step uses the pre-existing `queued`, and the new press is written to `queued` afterwards. The press wins over the consume-clear.
- `enable` falling mid-period: the counter resets to 0 and no pulse occurs.
- `rst` mid-operation: all state returns to reset values on the next edge, and any pending pulse is suppressed.

## Structure
- Shared package:
  - Direction constants RIGHT/LEFT/UP/DOWN.
  - 4-bit direction typedef.
  - A `reverse_dir` function.
  - Reuse the same constants in the position updater.
- Sub-module `button_debouncer`:
  - Contains the synchroniser, stability counter and registered level/edge outputs.
  - Parameterised by `DEBOUNCE_CYCLES` and instantiated 4×.
- Top-level contents: priority encoder, queue register, step counter, 3-state FSM.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `STEP_PERIOD` = 8.
1. Reset, then `enable` high with no buttons → `move_direction` stays 0000 forever, `heading` = 0000, `stalled` = 0.
2. `btn_right` pulse of 6 cycles, `valid_moves` = 1111 → `queued` = 0001, then at the next step a single pulse 0001 appears and `heading` = 0001. Subsequent steps emit 0001 every 8 cycles.
3. A 3-cycle glitch on `btn_up` → no press registered, and `queued` remains 0.
4. Heading RIGHT, `valid_moves` = 1000 → no pulse and `stalled` = 1. Then press LEFT → next step emits 1000, `heading` = 1000, `stalled` = 0.
5. Queued UP while heading RIGHT, `valid_moves` = 0001 for 2 steps then 0011 → 0001, 0001, then 0010 emitted; `queued` cleared after the 0010 pulse.
6. `btn_up` and `btn_left` rising together → `queued` = 0010. Then assert `rst` in the cycle before a step → no pulse, and all outputs return to 0.
